sgd_dispatch_mc: RTL and testbench
==================================

SGD_DISPATCH_MC -- requirements
Module: sgd_dispatch_mc

Interface
REQ-001 The block SHALL use one clock and a synchronous active-high reset; clk and rst are the only clock/reset ports.
REQ-002 The block SHALL expose these parameters:
- DATA_WIDTH, default 512: read-data beat width.
- ID_WIDTH, default 5: RID width.
- NUM_OF_BANKS, default 8: b lanes per output word.
- B_WIDTH, default 32: bits per b lane.
- NUM_A_CH, default 2: number of a output channels.
- A_TAG_BASE, default 0: RID of a-channel 0; channel k uses A_TAG_BASE+k.
- B_TAG, default 4: RID of b beats.
REQ-003 The block SHALL have these ports:
- clk in 1: clock.
- rst in 1: sync reset, active high.
- started in 1: start pulse.
- m_axi_RVALID in 1: read data valid.
- m_axi_RDATA in DATA_WIDTH: read data.
- m_axi_RLAST in 1: last beat; ignored.
- m_axi_RID in ID_WIDTH: beat tag.
- m_axi_RRESP in 2: response status.
- m_axi_RREADY out 1: registered ready.
- a_data out DATA_WIDTH: a beat, shared by all channels.
- a_wr_en out NUM_A_CH: one-hot write strobe.
- a_almost_full in NUM_A_CH: per-channel backpressure.
- b_data out B_WIDTH*NUM_OF_BANKS: b slice.
- b_wr_en out 1: b write strobe.
- b_almost_full in 1: b backpressure.
- stall_cnt out 32: cycles with backpressure active.
- drop_cnt out 32: accepted beats with unknown tag.
- err_cnt out 32: accepted beats with RRESP != 0.

Function
REQ-004 B_SLICES SHALL equal DATA_WIDTH/(B_WIDTH*NUM_OF_BANKS); a non-integer or zero value SHALL be a fatal elaboration error.
REQ-005 started_r SHALL set on the first cycle started=1 and hold until rst; m_axi_RREADY SHALL be 0 while started_r=0.
REQ-006 A beat SHALL be accepted in a cycle where m_axi_RVALID and m_axi_RREADY are both 1.
REQ-007 m_axi_RREADY SHALL be registered; its next value is started_r & ~(|a_almost_full) & ~b_almost_full & ~b_busy_next.
REQ-008 b_busy_next SHALL be 1 when a B_TAG beat is accepted this cycle, or when the b FSM is in WRITE and the current slice is not the final one emitted.
REQ-009 An accepted beat with RID=A_TAG_BASE+k (k<NUM_A_CH) SHALL produce a_wr_en[k]=1 and a_data=RDATA on the next cycle, with all other a_wr_en bits 0.
REQ-010 a_data SHALL be loaded on every cycle; it is meaningful only when a_wr_en is nonzero.
REQ-011 The b FSM SHALL have states IDLE, POLL and WRITE.
- IDLE -> POLL when started_r=1.
- POLL: on accepted B_TAG beat, capture RDATA into the b buffer, set slice index to 0, go to WRITE.
- WRITE: in each cycle with b_almost_full=0, emit slice[idx] and increment idx; after slice B_SLICES-1 is emitted, go to POLL.
- WRITE with b_almost_full=1: hold; b_wr_en=0 and idx unchanged.
REQ-012 Slice k SHALL be buffer bits [(k+1)*B_WIDTH*NUM_OF_BANKS-1 : k*B_WIDTH*NUM_OF_BANKS]; b_wr_en and b_data SHALL be registered.
REQ-013 Latency: a B beat accepted at cycle t SHALL give its first b_wr_en at t+2 when there is no backpressure, and consecutive slices on consecutive cycles after that.
REQ-014 An accepted beat matching no a tag and not B_TAG SHALL be discarded, and drop_cnt SHALL increment.
REQ-015 err_cnt SHALL increment on each accepted beat with RRESP != 0; such beats SHALL still be dispatched.
REQ-016 stall_cnt SHALL increment each cycle in which registered (|a_almost_full | b_almost_full) is 1.
REQ-017 All three counters SHALL saturate at 32'hFFFFFFFF.
REQ-018 When rst is not active, the outputs SHALL be driven only as specified in REQ-007 to REQ-017; no combinational path SHALL exist from any input to m_axi_RREADY.

Reset
REQ-019 While rst=1 on a clock edge:
- m_axi_RREADY, a_wr_en, b_wr_en, started_r and all counters SHALL be 0.
- The b FSM SHALL be in IDLE.
- a_data, b_data and the b buffer SHALL be don't-care.
REQ-020 rst asserted mid-WRITE SHALL abandon the remaining slices; no b_wr_en SHALL follow the reset edge.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- No started pulse; RVALID=1 with RID=0 for 10 cycles -> RREADY=0 throughout; no a_wr_en.
- started pulse; then RID=1 beat with data 0xAB..AB -> a_wr_en=2'b10 one cycle after acceptance, a_data=0xAB..AB.
- started; then B_TAG beat with data {256'h2, 256'h1} -> b_data=256'h1, then 256'h2 on consecutive b_wr_en cycles; RREADY=0 during WRITE.
- B write with b_almost_full=1 for 3 cycles after slice 0 -> slice 1 delayed 3 cycles; exactly 2 b_wr_en pulses; stall_cnt=3.
- RID=7 beat with RRESP=2 -> no a_wr_en or b_wr_en; drop_cnt=1; err_cnt=1.
- rst asserted on the cycle after slice 0 -> no further b_wr_en; RREADY=0; counters 0.

Source files
------------

// File: rtl/sgd_dispatch_mc.sv
// Read-data dispatcher: routes tagged read beats to the a channels or the b slicer,
// with registered flow control and saturating stall/drop/error counters.
module sgd_dispatch_mc #(
    parameter int DATA_WIDTH   = 512,
    parameter int ID_WIDTH     = 5,
    parameter int NUM_OF_BANKS = 8,
    parameter int B_WIDTH      = 32,
    parameter int NUM_A_CH     = 2,
    parameter int A_TAG_BASE   = 0,
    parameter int B_TAG        = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             started,
    input  logic                             m_axi_RVALID,
    input  logic [DATA_WIDTH-1:0]            m_axi_RDATA,
    input  logic                             m_axi_RLAST,
    input  logic [ID_WIDTH-1:0]              m_axi_RID,
    input  logic [1:0]                       m_axi_RRESP,
    output logic                             m_axi_RREADY,
    output logic [DATA_WIDTH-1:0]            a_data,
    output logic [NUM_A_CH-1:0]              a_wr_en,
    input  logic [NUM_A_CH-1:0]              a_almost_full,
    output logic [B_WIDTH*NUM_OF_BANKS-1:0]  b_data,
    output logic                             b_wr_en,
    input  logic                             b_almost_full,
    output logic [31:0]                      stall_cnt,
    output logic [31:0]                      drop_cnt,
    output logic [31:0]                      err_cnt
);
    localparam int SLICE_W  = B_WIDTH * NUM_OF_BANKS;
    localparam int B_SLICES = (SLICE_W > 0) ? DATA_WIDTH / SLICE_W : 0;
    localparam int IDX_W    = (B_SLICES > 1) ? $clog2(B_SLICES) : 1;

    generate
        if (SLICE_W <= 0 || B_SLICES == 0 || (DATA_WIDTH % SLICE_W) != 0) begin : g_bad_geometry
            $fatal(1, "sgd_dispatch_mc: DATA_WIDTH must be a nonzero multiple of B_WIDTH*NUM_OF_BANKS");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_POLL, S_WRITE} b_state_t;

    b_state_t                r_state;
    b_state_t                w_state_next;
    logic                    r_started;
    logic                    r_rready;
    logic                    r_bp;
    logic [NUM_A_CH-1:0]     r_a_wr_en;
    logic [DATA_WIDTH-1:0]   r_a_data;
    logic [DATA_WIDTH-1:0]   r_b_buf;
    logic [SLICE_W-1:0]      r_b_data;
    logic                    r_b_wr_en;
    logic [IDX_W-1:0]        r_idx;
    logic [31:0]             r_stall_cnt;
    logic [31:0]             r_drop_cnt;
    logic [31:0]             r_err_cnt;

    logic                    w_accept;
    logic                    w_is_b;
    logic [NUM_A_CH-1:0]     w_a_hit;
    logic                    w_last_slice;
    logic                    w_emit;
    logic                    w_load;
    logic                    w_b_busy_next;
    logic [SLICE_W-1:0]      w_slice;
    logic                    w_unused_rlast;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    assign w_unused_rlast = m_axi_RLAST;
    assign w_accept       = m_axi_RVALID & r_rready;
    assign w_is_b         = (m_axi_RID == ID_WIDTH'(B_TAG));
    assign w_last_slice   = (r_idx == IDX_W'(B_SLICES - 1));
    assign w_slice        = SLICE_W'(r_b_buf >> (int'(r_idx) * SLICE_W));

    always_comb begin
        w_a_hit = '0;
        for (int k = 0; k < NUM_A_CH; k++) begin
            w_a_hit[k] = (m_axi_RID == ID_WIDTH'(A_TAG_BASE + k));
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_emit       = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            S_IDLE:  if (r_started) w_state_next = S_POLL;
            S_POLL: begin
                if (w_accept && w_is_b) begin
                    w_load       = 1'b1;
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!b_almost_full) begin
                    w_emit = 1'b1;
                    if (w_last_slice) w_state_next = S_POLL;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Ready drops while a b beat is still being sliced out, so a new b beat never overwrites the buffer.
    assign w_b_busy_next = (w_accept & w_is_b) | ((r_state == S_WRITE) & ~(w_emit & w_last_slice));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_started   <= 1'b0;
            r_rready    <= 1'b0;
            r_bp        <= 1'b0;
            r_a_wr_en   <= '0;
            r_b_wr_en   <= 1'b0;
            r_idx       <= '0;
            r_stall_cnt <= '0;
            r_drop_cnt  <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_state     <= w_state_next;
            r_started   <= r_started | started;
            r_rready    <= r_started & ~(|a_almost_full) & ~b_almost_full & ~w_b_busy_next;
            r_bp        <= (|a_almost_full) | b_almost_full;
            r_a_wr_en   <= w_accept ? w_a_hit : '0;
            r_b_wr_en   <= w_emit;
            if (w_load) begin
                r_idx <= '0;
            end else if (w_emit) begin
                r_idx <= r_idx + IDX_W'(1);
            end
            r_stall_cnt <= sat_inc(r_stall_cnt, r_bp);
            r_drop_cnt  <= sat_inc(r_drop_cnt, w_accept & ~(|w_a_hit) & ~w_is_b);
            r_err_cnt   <= sat_inc(r_err_cnt, w_accept & (m_axi_RRESP != 2'b00));
        end
    end

    // Data paths carry no reset; they are only meaningful alongside their strobes.
    always_ff @(posedge clk) begin
        r_a_data <= m_axi_RDATA;
        if (w_load) r_b_buf <= m_axi_RDATA;
        if (w_emit) r_b_data <= w_slice;
    end

    assign m_axi_RREADY = r_rready;
    assign a_data       = r_a_data;
    assign a_wr_en      = r_a_wr_en;
    assign b_data       = r_b_data;
    assign b_wr_en      = r_b_wr_en;
    assign stall_cnt    = r_stall_cnt;
    assign drop_cnt     = r_drop_cnt;
    assign err_cnt      = r_err_cnt;
endmodule

// File: tb/tb_sgd_dispatch_mc.sv
// Bench for sgd_dispatch_mc: directed scenarios plus random traffic against a
// queue-based transaction model, compared on every falling clock edge.
module tb_sgd_dispatch_mc;
  localparam int DW    = 512;
  localparam int IDW   = 5;
  localparam int NB    = 8;
  localparam int BW    = 32;
  localparam int NA    = 2;
  localparam int ABASE = 0;
  localparam int BTAG  = 4;
  localparam int SW    = BW * NB;
  localparam int NS    = DW / SW;

  logic            clk;
  logic            rst;
  logic            started;
  logic            m_axi_RVALID;
  logic [DW-1:0]   m_axi_RDATA;
  logic            m_axi_RLAST;
  logic [IDW-1:0]  m_axi_RID;
  logic [1:0]      m_axi_RRESP;
  logic            m_axi_RREADY;
  logic [DW-1:0]   a_data;
  logic [NA-1:0]   a_wr_en;
  logic [NA-1:0]   a_almost_full;
  logic [SW-1:0]   b_data;
  logic            b_wr_en;
  logic            b_almost_full;
  logic [31:0]     stall_cnt;
  logic [31:0]     drop_cnt;
  logic [31:0]     err_cnt;

  sgd_dispatch_mc #(
    .DATA_WIDTH(DW), .ID_WIDTH(IDW), .NUM_OF_BANKS(NB), .B_WIDTH(BW),
    .NUM_A_CH(NA), .A_TAG_BASE(ABASE), .B_TAG(BTAG)
  ) dut (
    .clk(clk), .rst(rst), .started(started),
    .m_axi_RVALID(m_axi_RVALID), .m_axi_RDATA(m_axi_RDATA), .m_axi_RLAST(m_axi_RLAST),
    .m_axi_RID(m_axi_RID), .m_axi_RRESP(m_axi_RRESP), .m_axi_RREADY(m_axi_RREADY),
    .a_data(a_data), .a_wr_en(a_wr_en), .a_almost_full(a_almost_full),
    .b_data(b_data), .b_wr_en(b_wr_en), .b_almost_full(b_almost_full),
    .stall_cnt(stall_cnt), .drop_cnt(drop_cnt), .err_cnt(err_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: pending b slices live in a queue
  bit              m_on = 1'b0;
  logic            m_started, m_rready, m_bp;
  logic [NA-1:0]   e_a_en;
  logic [DW-1:0]   e_a_data;
  logic            e_b_en;
  logic [SW-1:0]   e_b_data;
  logic [31:0]     e_stall, e_drop, e_err;
  logic [SW-1:0]   exp_q[$];
  logic            m_acc, m_is_a, m_is_b, m_af;
  int              m_rid;

  function automatic logic [31:0] sat(input logic [31:0] v, input logic en);
    if (en && v != 32'hFFFF_FFFF) return v + 32'd1;
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_on = 1'b1;
      m_started = 1'b0; m_rready = 1'b0; m_bp = 1'b0;
      e_a_en = '0; e_b_en = 1'b0;
      e_stall = '0; e_drop = '0; e_err = '0;
      exp_q.delete();
    end else if (m_on) begin
      m_acc  = m_axi_RVALID && m_rready;
      m_rid  = int'(m_axi_RID);
      m_is_a = m_acc && (m_rid >= ABASE) && (m_rid < ABASE + NA);
      m_is_b = m_acc && (m_rid == BTAG);
      e_a_en = m_is_a ? NA'(1 << (m_rid - ABASE)) : '0;
      e_a_data = m_axi_RDATA;
      e_b_en = 1'b0;
      if (exp_q.size() > 0 && !b_almost_full) begin
        e_b_en = 1'b1;
        e_b_data = exp_q.pop_front();
      end
      if (m_is_b) begin
        for (int s = 0; s < NS; s++) exp_q.push_back(m_axi_RDATA[s*SW +: SW]);
      end
      m_af = (|a_almost_full) || b_almost_full;
      e_stall = sat(e_stall, m_bp);
      m_bp = m_af;
      e_drop = sat(e_drop, m_acc && !m_is_a && !m_is_b);
      e_err = sat(e_err, m_acc && (m_axi_RRESP != 2'b00));
      m_rready = m_started && !m_af && (exp_q.size() == 0);
      m_started = m_started | started;
    end
  end

  // scoreboard compare, one per cycle
  always @(negedge clk) begin
    if (m_on) begin
      check("rready", DW'(m_axi_RREADY), DW'(m_rready));
      check("a_wr_en", DW'(a_wr_en), DW'(e_a_en));
      if (e_a_en != '0) check("a_data", a_data, e_a_data);
      check("b_wr_en", DW'(b_wr_en), DW'(e_b_en));
      if (e_b_en) check("b_data", DW'(b_data), DW'(e_b_data));
      check("stall_cnt", DW'(stall_cnt), DW'(e_stall));
      check("drop_cnt", DW'(drop_cnt), DW'(e_drop));
      check("err_cnt", DW'(err_cnt), DW'(e_err));
    end
  end

  // strobe history for directed checks
  int cyc = 0;
  int b_cyc_q[$];
  int a_pulses = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (b_wr_en === 1'b1) b_cyc_q.push_back(cyc);
    if (a_wr_en !== '0 && m_on) a_pulses++;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; started = 1'b0; m_axi_RVALID = 1'b0;
    a_almost_full = '0; b_almost_full = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    started = 1'b1;
    tick();
    started = 1'b0;
  endtask

  task automatic send(input int rid, input logic [DW-1:0] data, input logic [1:0] resp);
    logic r;
    bit ok;
    ok = 1'b0;
    m_axi_RVALID = 1'b1; m_axi_RID = IDW'(rid); m_axi_RDATA = data;
    m_axi_RRESP = resp; m_axi_RLAST = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      r = m_axi_RREADY;
      tick();
      if (r === 1'b1) ok = 1'b1;
    end
    m_axi_RVALID = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: rid %0d not accepted within 50 cycles", rid);
    end
  endtask

  logic [DW-1:0] d;

  initial begin
    rst = 1'b1; started = 1'b0; m_axi_RVALID = 1'b0; m_axi_RDATA = '0;
    m_axi_RLAST = 1'b0; m_axi_RID = '0; m_axi_RRESP = '0;
    a_almost_full = '0; b_almost_full = 1'b0;

    // no started pulse: ready stays low
    do_reset();
    m_axi_RVALID = 1'b1; m_axi_RID = '0; m_axi_RDATA = {16{32'h1234_5678}};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("s1_rready", DW'(m_axi_RREADY), '0);
      check("s1_a_wr_en", DW'(a_wr_en), '0);
      tick();
    end
    m_axi_RVALID = 1'b0;

    // a channel 1 beat
    do_reset();
    pulse_start();
    d = {64{8'hAB}};
    send(1, d, 2'b00);
    @(negedge clk);
    check("s2_a_wr_en", DW'(a_wr_en), DW'(2'b10));
    check("s2_a_data", a_data, d);
    tick();

    // b beat sliced low half first
    do_reset();
    pulse_start();
    d = {256'h2, 256'h1};
    send(BTAG, d, 2'b00);
    @(negedge clk);
    check("s3_b_wr_en_t1", DW'(b_wr_en), '0);
    check("s3_rready_t1", DW'(m_axi_RREADY), '0);
    tick();
    @(negedge clk);
    check("s3_b_wr_en_t2", DW'(b_wr_en), DW'(1));
    check("s3_b_data_0", DW'(b_data), DW'(256'h1));
    check("s3_rready_t2", DW'(m_axi_RREADY), '0);
    tick();
    @(negedge clk);
    check("s3_b_wr_en_t3", DW'(b_wr_en), DW'(1));
    check("s3_b_data_1", DW'(b_data), DW'(256'h2));
    check("s3_rready_t3", DW'(m_axi_RREADY), DW'(1));
    tick();

    // b backpressure for 3 cycles after slice 0
    do_reset();
    pulse_start();
    b_cyc_q.delete();
    send(BTAG, {256'hBB, 256'hAA}, 2'b00);
    tick();
    b_almost_full = 1'b1;
    tick(); tick(); tick();
    b_almost_full = 1'b0;
    repeat (6) tick();
    check("s4_b_pulses", DW'(b_cyc_q.size()), DW'(2));
    if (b_cyc_q.size() == 2) check("s4_slice_gap", DW'(b_cyc_q[1] - b_cyc_q[0]), DW'(4));
    check("s4_stall_cnt", DW'(stall_cnt), DW'(3));

    // unknown tag with error response
    do_reset();
    pulse_start();
    b_cyc_q.delete();
    a_pulses = 0;
    send(7, {16{32'hDEAD_BEEF}}, 2'b10);
    repeat (4) tick();
    check("s5_drop_cnt", DW'(drop_cnt), DW'(1));
    check("s5_err_cnt", DW'(err_cnt), DW'(1));
    check("s5_b_pulses", DW'(b_cyc_q.size()), '0);
    check("s5_a_pulses", DW'(a_pulses), '0);

    // reset during WRITE abandons slice 1
    do_reset();
    pulse_start();
    b_cyc_q.delete();
    send(BTAG, {256'h22, 256'h11}, 2'b00);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("s6_b_wr_en", DW'(b_wr_en), '0);
      check("s6_rready", DW'(m_axi_RREADY), '0);
      tick();
    end
    check("s6_b_pulses", DW'(b_cyc_q.size()), DW'(1));
    check("s6_stall_cnt", DW'(stall_cnt), '0);
    check("s6_drop_cnt", DW'(drop_cnt), '0);
    check("s6_err_cnt", DW'(err_cnt), '0);

    // random traffic against the model
    do_reset();
    pulse_start();
    for (int i = 0; i < 3000; i++) begin
      m_axi_RVALID = 1'($urandom_range(0, 1));
      m_axi_RID = IDW'($urandom_range(0, 7));
      for (int w = 0; w < DW / 32; w++) m_axi_RDATA[w*32 +: 32] = $urandom();
      m_axi_RRESP = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      m_axi_RLAST = 1'($urandom_range(0, 1));
      a_almost_full = ($urandom_range(0, 7) == 0) ? NA'($urandom_range(1, 3)) : '0;
      b_almost_full = ($urandom_range(0, 5) == 0);
      started = ($urandom_range(0, 99) == 0);
      rst = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 1'b0; started = 1'b0; m_axi_RVALID = 1'b0;
    a_almost_full = '0; b_almost_full = 1'b0;
    repeat (8) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
